// File: rtl/servant_ram_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the shared RAM port.
// The arbiter connects through the slave modport; the environment uses the master modport.
interface servant_ram_arbiter_if #(
   parameter int aw = 8
);
   logic [aw-1:2] i_m0_adr;
   logic [31:0]   i_m0_dat;
   logic [3:0]    i_m0_sel;
   logic          i_m0_we;
   logic          i_m0_cyc;
   logic [31:0]   o_m0_rdt;
   logic          o_m0_ack;

   logic [aw-1:2] i_m1_adr;
   logic [31:0]   i_m1_dat;
   logic [3:0]    i_m1_sel;
   logic          i_m1_we;
   logic          i_m1_cyc;
   logic [31:0]   o_m1_rdt;
   logic          o_m1_ack;

   logic [aw-1:2] o_s_adr;
   logic [31:0]   o_s_dat;
   logic [3:0]    o_s_sel;
   logic          o_s_we;
   logic          o_s_cyc;
   logic [31:0]   i_s_rdt;
   logic          i_s_ack;

   logic          o_timeout;

   modport slave (
      input  i_m0_adr, i_m0_dat, i_m0_sel, i_m0_we, i_m0_cyc,
      output o_m0_rdt, o_m0_ack,
      input  i_m1_adr, i_m1_dat, i_m1_sel, i_m1_we, i_m1_cyc,
      output o_m1_rdt, o_m1_ack,
      output o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc,
      input  i_s_rdt, i_s_ack,
      output o_timeout
   );

   modport master (
      output i_m0_adr, i_m0_dat, i_m0_sel, i_m0_we, i_m0_cyc,
      input  o_m0_rdt, o_m0_ack,
      output i_m1_adr, i_m1_dat, i_m1_sel, i_m1_we, i_m1_cyc,
      input  o_m1_rdt, o_m1_ack,
      input  o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc,
      output i_s_rdt, i_s_ack,
      input  o_timeout
   );
endinterface

// File: rtl/servant_ram_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the servant RAM, with a
// watchdog that aborts a transaction the RAM never acknowledges.
module servant_ram_arbiter #(
   parameter int aw      = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   servant_ram_arbiter_if.slave bus
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   state_t        state;
   logic          grant;
   logic          last_grant;
   logic [CW-1:0] cnt;
   logic          pick;

   // On a tie the master that did not win last time gets the port.
   always_comb begin
      pick = bus.i_m1_cyc;
      if (bus.i_m0_cyc && bus.i_m1_cyc)
         pick = ~last_grant;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= IDLE;
         grant         <= 1'b0;
         last_grant    <= 1'b1;
         cnt           <= '0;
         bus.o_s_adr   <= '0;
         bus.o_s_dat   <= '0;
         bus.o_s_sel   <= '0;
         bus.o_s_we    <= 1'b0;
         bus.o_s_cyc   <= 1'b0;
         bus.o_m0_rdt  <= '0;
         bus.o_m0_ack  <= 1'b0;
         bus.o_m1_rdt  <= '0;
         bus.o_m1_ack  <= 1'b0;
         bus.o_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_m0_cyc || bus.i_m1_cyc) begin
                  grant       <= pick;
                  last_grant  <= pick;
                  bus.o_s_adr <= pick ? bus.i_m1_adr : bus.i_m0_adr;
                  bus.o_s_dat <= pick ? bus.i_m1_dat : bus.i_m0_dat;
                  bus.o_s_sel <= pick ? bus.i_m1_sel : bus.i_m0_sel;
                  bus.o_s_we  <= pick ? bus.i_m1_we  : bus.i_m0_we;
                  bus.o_s_cyc <= 1'b1;
                  cnt         <= '0;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt + CW'(1);
               if (bus.i_s_ack) begin
                  if (grant) begin
                     bus.o_m1_rdt <= bus.i_s_rdt;
                     bus.o_m1_ack <= 1'b1;
                  end else begin
                     bus.o_m0_rdt <= bus.i_s_rdt;
                     bus.o_m0_ack <= 1'b1;
                  end
                  bus.o_s_cyc <= 1'b0;
                  bus.o_s_we  <= 1'b0;
                  state       <= ACK;
               end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                  // Abort: release the master with zero data and flag it permanently.
                  if (grant) begin
                     bus.o_m1_rdt <= '0;
                     bus.o_m1_ack <= 1'b1;
                  end else begin
                     bus.o_m0_rdt <= '0;
                     bus.o_m0_ack <= 1'b1;
                  end
                  bus.o_s_cyc   <= 1'b0;
                  bus.o_timeout <= 1'b1;
                  state         <= ACK;
               end
            end
            ACK: begin
               bus.o_m0_ack <= 1'b0;
               bus.o_m1_ack <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// Bench for servant_ram_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of round-robin grants and RAM contents.
module tb_servant_ram_arbiter;

   localparam int AW = 8;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   servant_ram_arbiter_if #(.aw(AW)) bus ();

   servant_ram_arbiter #(.aw(AW), .TIMEOUT(TO)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Single-cycle RAM slave; returns the word as it was before any write.
   logic [31:0] ram [0:63];
   logic        ram_mute = 1'b0;
   logic        ram_clr  = 1'b0;
   logic        pre_en   = 1'b0;
   logic [5:0]  pre_adr  = '0;
   logic [31:0] pre_dat  = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.i_s_ack <= 1'b0;
         bus.i_s_rdt <= '0;
      end else begin
         bus.i_s_ack <= 1'b0;
         if (bus.o_s_cyc && !bus.i_s_ack && !ram_mute) begin
            bus.i_s_ack <= 1'b1;
            bus.i_s_rdt <= ram[bus.o_s_adr];
         end
      end
   end

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 64; i++) ram[i] <= '0;
      end else if (pre_en) begin
         ram[pre_adr] <= pre_dat;
      end else if (!rst && bus.o_s_cyc && !bus.i_s_ack && !ram_mute && bus.o_s_we) begin
         for (int b = 0; b < 4; b++)
            if (bus.o_s_sel[b]) ram[bus.o_s_adr][8*b +: 8] <= bus.o_s_dat[8*b +: 8];
      end
   end

   typedef struct packed {
      logic        cyc;
      logic        we;
      logic [5:0]  adr;
      logic [3:0]  sel;
      logic [31:0] dat;
   } req_t;

   req_t        rq [2];
   logic [31:0] mdl_mem [64];
   logic [31:0] mdl_rdt [2];
   int          mdl_last;
   logic        mdl_to;
   int          n_tot = 0;
   int          n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive();
      bus.i_m0_cyc = rq[0].cyc; bus.i_m0_we = rq[0].we; bus.i_m0_adr = rq[0].adr;
      bus.i_m0_sel = rq[0].sel; bus.i_m0_dat = rq[0].dat;
      bus.i_m1_cyc = rq[1].cyc; bus.i_m1_we = rq[1].we; bus.i_m1_adr = rq[1].adr;
      bus.i_m1_sel = rq[1].sel; bus.i_m1_dat = rq[1].dat;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic ack_of(input int i);
      return (i == 1) ? bus.o_m1_ack : bus.o_m0_ack;
   endfunction

   function automatic logic [31:0] rdt_of(input int i);
      return (i == 1) ? bus.o_m1_rdt : bus.o_m0_rdt;
   endfunction

   function automatic int model_pick();
      if (rq[0].cyc && rq[1].cyc) return 1 - mdl_last;
      return rq[1].cyc ? 1 : 0;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {17'd0, bus.o_m0_ack, bus.o_m1_ack, bus.o_s_cyc, bus.o_s_we,
                          bus.o_timeout, bus.o_s_sel, bus.o_s_adr}, 32'd0);
      chk({tag, "_m0rdt"}, bus.o_m0_rdt, 32'd0);
      chk({tag, "_m1rdt"}, bus.o_m1_rdt, 32'd0);
      chk({tag, "_sdat"}, bus.o_s_dat, 32'd0);
   endtask

   task automatic model_reset();
      mdl_last   = 1;
      mdl_rdt[0] = '0;
      mdl_rdt[1] = '0;
      mdl_to     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      chk_zero("rst");
      rst = 1'b0;
      model_reset();
   endtask

   // Advance from the ack cycle into IDLE; the ack must have been a single pulse.
   task automatic idle_step();
      tick();
      chk("ack_pulse", {30'd0, bus.o_m1_ack, bus.o_m0_ack}, 32'd0);
   endtask

   // Called at the negedge of a cycle where the arbiter is IDLE with requests driven.
   task automatic run_txn(input bit to_exp, output int w);
      int          l, k, loser_acks;
      bit          seen;
      logic [31:0] mw, exp_rdt;
      w  = model_pick();
      l  = 1 - w;
      mdl_last = w;
      mw = mdl_mem[rq[w].adr];
      exp_rdt = to_exp ? 32'd0 : mw;
      if (!to_exp && rq[w].we) begin
         for (int b = 0; b < 4; b++)
            if (rq[w].sel[b]) mw[8*b +: 8] = rq[w].dat[8*b +: 8];
         mdl_mem[rq[w].adr] = mw;
      end
      if (to_exp) mdl_to = 1'b1;

      tick();
      chk("s_cyc", {31'd0, bus.o_s_cyc}, 32'd1);
      chk("s_adr", {26'd0, bus.o_s_adr}, {26'd0, rq[w].adr});
      chk("s_dat", bus.o_s_dat, rq[w].dat);
      chk("s_sel", {28'd0, bus.o_s_sel}, {28'd0, rq[w].sel});
      chk("s_we", {31'd0, bus.o_s_we}, {31'd0, rq[w].we});

      seen = 1'b0;
      k = 1;
      loser_acks = 0;
      while (!seen && k < 40) begin
         tick();
         k++;
         if (ack_of(l)) loser_acks++;
         if (ack_of(w)) seen = 1'b1;
      end
      chk("ack_lat", k, to_exp ? 32'd16 : 32'd3);
      chk("loser_ack", loser_acks, 32'd0);
      chk("win_rdt", rdt_of(w), exp_rdt);
      chk("loser_rdt", rdt_of(l), mdl_rdt[l]);
      chk("s_cyc_off", {31'd0, bus.o_s_cyc}, 32'd0);
      chk("timeout", {31'd0, bus.o_timeout}, {31'd0, mdl_to});
      mdl_rdt[w] = exp_rdt;
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.cyc = 1'b1;
      r.we  = 1'($urandom_range(0, 1));
      r.adr = 6'($urandom_range(0, 7));
      r.sel = 4'($urandom_range(1, 15));
      r.dat = $urandom;
      return r;
   endfunction

   initial begin
      #400000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench time limit exceeded");
   end

   initial begin
      int w;
      rq[0] = '0;
      rq[1] = '0;
      drive();
      for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
      model_reset();

      @(negedge clk);
      ram_clr = 1'b1;
      tick();
      ram_clr = 1'b0;
      pre_en  = 1'b1;
      pre_adr = 6'd5;
      pre_dat = 32'hDEADBEEF;
      mdl_mem[5] = 32'hDEADBEEF;
      tick();
      pre_en = 1'b0;
      do_reset();

      // Single m0 read.
      rq[0] = '{cyc: 1'b1, we: 1'b0, adr: 6'd5, sel: 4'hF, dat: 32'd0};
      drive();
      run_txn(1'b0, w);
      chk("m0_read", bus.o_m0_rdt, 32'hDEADBEEF);
      rq[0].cyc = 1'b0;
      drive();
      tick();

      // Simultaneous requests after reset, held for four transactions.
      do_reset();
      rq[0] = '{cyc: 1'b1, we: 1'b1, adr: 6'd1, sel: 4'hF, dat: 32'h11223344};
      rq[1] = '{cyc: 1'b1, we: 1'b0, adr: 6'd1, sel: 4'hF, dat: 32'd0};
      drive();
      run_txn(1'b0, w);
      chk("first_grant", w, 32'd0);
      idle_step();
      run_txn(1'b0, w);
      chk("m1_sees_write", bus.o_m1_rdt, 32'h11223344);
      idle_step();
      run_txn(1'b0, w);
      idle_step();
      run_txn(1'b0, w);

      // Byte-lane write from m1, then read back.
      rq[0] = '0;
      rq[1] = '{cyc: 1'b1, we: 1'b1, adr: 6'd2, sel: 4'h4, dat: 32'h12AB3456};
      drive();
      idle_step();
      run_txn(1'b0, w);
      rq[1] = '{cyc: 1'b1, we: 1'b0, adr: 6'd2, sel: 4'hF, dat: 32'd0};
      drive();
      idle_step();
      run_txn(1'b0, w);
      chk("byte_rb", bus.o_m1_rdt, 32'h00AB0000);

      // Watchdog abort, then a normal transaction.
      ram_mute = 1'b1;
      rq[1] = '0;
      rq[0] = '{cyc: 1'b1, we: 1'b0, adr: 6'd3, sel: 4'hF, dat: 32'd0};
      drive();
      idle_step();
      run_txn(1'b1, w);
      ram_mute = 1'b0;
      rq[0] = '{cyc: 1'b1, we: 1'b0, adr: 6'd5, sel: 4'hF, dat: 32'd0};
      drive();
      idle_step();
      run_txn(1'b0, w);
      chk("after_to_rdt", bus.o_m0_rdt, 32'hDEADBEEF);

      // Asynchronous reset in the middle of a transaction.
      rq[0] = '{cyc: 1'b1, we: 1'b0, adr: 6'd1, sel: 4'hF, dat: 32'd0};
      drive();
      idle_step();
      tick();
      chk("busy_cyc", {31'd0, bus.o_s_cyc}, 32'd1);
      #1 rst = 1'b1;
      #1 chk_zero("async_rst");
      rq[0] = '0;
      drive();
      tick();
      tick();
      chk("no_ack_rst", {30'd0, bus.o_m1_ack, bus.o_m0_ack}, 32'd0);
      rst = 1'b0;
      model_reset();
      rq[1] = '{cyc: 1'b1, we: 1'b0, adr: 6'd5, sel: 4'hF, dat: 32'd0};
      drive();
      run_txn(1'b0, w);
      chk("m1_after_rst", w, 32'd1);

      // m0 keeps cyc through its ack cycle; no second RAM access follows.
      rq[1] = '0;
      rq[0] = '{cyc: 1'b1, we: 1'b0, adr: 6'd7, sel: 4'hF, dat: 32'd0};
      drive();
      idle_step();
      run_txn(1'b0, w);
      @(posedge clk);
      #1;
      rq[0].cyc = 1'b0;
      drive();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_dup_cyc", {31'd0, bus.o_s_cyc}, 32'd0);
      end
      rq[0].cyc = 1'b1;
      drive();
      run_txn(1'b0, w);

      // Random traffic: the winner issues a fresh request, the loser keeps waiting.
      rq[0] = rand_req();
      rq[1] = rand_req();
      rq[1].cyc = 1'($urandom_range(0, 1));
      drive();
      for (int t = 0; t < 40; t++) begin
         idle_step();
         run_txn(1'b0, w);
         rq[w] = rand_req();
         if ($urandom_range(0, 3) == 0) rq[w].cyc = 1'b0;
         if (!rq[0].cyc && !rq[1].cyc) rq[w].cyc = 1'b1;
         drive();
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
